instruction_loader: RTL and testbench
=====================================

# instruction_loader

Loads a program image into the instruction memory from a byte stream. Sits between a host-side byte source (UART receiver, debug port or testbench) and the instruction memory's write port. Parses a 16-bit word-count header, assembles 32-bit instructions MSB-first and issues word-aligned writes starting at byte address 0. Signals completion or error to the controller holding the CPU in reset.

## Interface
- DATA_WIDTH, 32, instruction word width; must be 32.
- MEM_DEPTH, 256, instruction memory depth in words; maximum loadable count.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- Start  in  1  one-cycle pulse; begins a load when idle.
- In_Valid  in  1  byte on In_Data is valid.
- In_Data  in  8  stream byte.
- In_Ready  out  1  loader accepts a byte this cycle.
- Wr_En  out  1  one-cycle instruction memory write strobe.
- Wr_Address  out  DATA_WIDTH  byte address, always a multiple of 4.
- Wr_Data  out  DATA_WIDTH  assembled instruction word.
- Busy  out  1  high from accepted Start until Done.
- Done  out  1  one-cycle pulse at end of load, success or error.
- Error  out  1  sticky status; cleared by the next accepted Start or by rst.

## Operation
- Clock and reset are decided: single clock clk; rst is synchronous and active-high.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK (only with the macro), FINISH.
- IDLE: In_Ready=0. When Start=1, clear Error, word index, byte counter and checksum, then go to LEN_LO. Start in any other state is ignored.
- LEN_LO / LEN_HI: accept count N, low byte then high byte (16-bit, little-endian).
- After LEN_HI:
  - N==0: go to FINISH (CHECK if enabled).
  - N>MEM_DEPTH: set Error, go to FINISH, no writes.
  - Otherwise: go to DATA.
- DATA: each instruction is 4 bytes, MSB first. The first byte lands in bits 31:24, so the opcode field (bits 31:27) arrives first.
- On the 4th byte of word k, register the write: Wr_Data = assembled word, Wr_Address = k*4.
- After word N-1, go to FINISH (or CHECK).
- Byte transfer occurs only when In_Valid & In_Ready. In_Valid low stalls indefinitely with state held. There is no timeout.
- FINISH: Done=1 for one cycle, Busy drops in the same cycle, then go to IDLE.
- The word-index counter is 16 bits wide. Wr_Address = {index, 2'b00} zero-extended to DATA_WIDTH; it never wraps because N≤MEM_DEPTH.

## Timing
- Reset values: In_Ready=0, Wr_En=0, Wr_Address=0, Wr_Data=0, Busy=0, Done=0, Error=0, state IDLE.
- Busy and In_Ready rise the cycle after Start is sampled.
- In_Ready is combinational from state: 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 otherwise.
- Wr_En is asserted the cycle after the 4th byte of a word is accepted. Wr_Address and Wr_Data are valid with it and hold until the next write.
- Throughput: 1 byte/cycle sustained, so back-to-back words produce Wr_En every 4 cycles.
- Done is asserted the cycle after the final byte is accepted (coincident with the last Wr_En when there is no CHECK), or the cycle after LEN_HI for N==0 or error.
- rst mid-load: return to IDLE next edge; discard the partial word; no further Wr_En. Writes already issued remain in memory.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last data byte, CHECK accepts one byte that must equal the XOR of all header and data bytes.
  - On mismatch, set Error. All writes have already occurred.
  - CHECK is also entered for N==0. It is skipped on the N>MEM_DEPTH error.
- LOADER_CHECKSUM_EN undefined: no CHECK state, no checksum logic. The stream ends after the last data byte.

## Test plan
- Single word: Start; bytes 01 00 00 44 30 00 -> one Wr_En with Wr_Address=0, Wr_Data=32'h00443000; Done one cycle later-or-same per Timing; Error=0.
- Three words with In_Valid toggling every other cycle -> writes to addresses 0, 4, 8 with correct data, no lost or duplicated bytes, Busy high throughout.
- Count 00 00 -> no Wr_En; Done 1 cycle after LEN_HI (after the checksum byte 00 if enabled); Error=0.
- Count 01 01 (257 > 256) -> no Wr_En, Error=1, Done pulse. The next Start clears Error.
- rst asserted after 2 bytes of word 1 -> all outputs return to reset values next edge; a fresh load then writes address 0 first.
- With LOADER_CHECKSUM_EN: single-word stream above followed by checksum 75 -> Error=0. Followed by 74 -> Error=1, write still performed.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Byte-stream in / instruction-memory write port out bundle for instruction_loader.
// Host side drives through master; the loader attaches through slave.
interface instruction_loader_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  Start;
   logic                  In_Valid;
   logic [7:0]            In_Data;
   logic                  In_Ready;
   logic                  Wr_En;
   logic [DATA_WIDTH-1:0] Wr_Address;
   logic [DATA_WIDTH-1:0] Wr_Data;
   logic                  Busy;
   logic                  Done;
   logic                  Error;

   modport master (
      output Start, In_Valid, In_Data,
      input  In_Ready, Wr_En, Wr_Address, Wr_Data,
      input  Busy, Done, Error
   );

   modport slave (
      input  Start, In_Valid, In_Data,
      output In_Ready, Wr_En, Wr_Address, Wr_Data,
      output Busy, Done, Error
   );
endinterface

// File: rtl/instruction_loader.sv
// Streams a length-prefixed program image into instruction memory, MSB-first words.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instruction_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 256
) (
   input logic clk,
   input logic rst,
   instruction_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
`ifdef LOADER_CHECKSUM_EN
      CHECK,
`endif
      FINISH
   } state_t;

   state_t                state;
   state_t                state_nx;
   state_t                post;
   logic                  ready;
   logic                  busy;
   logic                  xfer;
   logic                  over;
   logic [15:0]           len;
   logic [15:0]           count;
   logic [15:0]           idx;
   logic [1:0]            bcnt;
   logic [23:0]           shift;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  error;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum;

   assign post = CHECK;
`else
   assign post = FINISH;
`endif

   // len is the full count as it completes on the LEN_HI byte
   assign len  = {bus.In_Data, count[7:0]};
   assign over = 32'(len) > 32'(MEM_DEPTH);
   assign xfer = bus.In_Valid & ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      busy     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.Start) state_nx = LEN_LO;
         end
         LEN_LO: begin
            ready = 1'b1;
            busy  = 1'b1;
            if (bus.In_Valid) state_nx = LEN_HI;
         end
         LEN_HI: begin
            ready = 1'b1;
            busy  = 1'b1;
            if (bus.In_Valid) begin
               if (len == 16'd0) state_nx = post;
               else if (over)    state_nx = FINISH;
               else              state_nx = DATA;
            end
         end
         DATA: begin
            ready = 1'b1;
            busy  = 1'b1;
            if (bus.In_Valid && bcnt == 2'd3 &&
                idx == count - 16'd1)
               state_nx = post;
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            ready = 1'b1;
            busy  = 1'b1;
            if (bus.In_Valid) state_nx = FINISH;
         end
`endif
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         idx     <= '0;
         bcnt    <= '0;
         shift   <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         error   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum    <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         if (state == IDLE && bus.Start) begin
            error <= 1'b0;
            idx   <= '0;
            bcnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
         end
         if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ bus.In_Data;
`endif
            unique case (state)
               LEN_LO: count[7:0] <= bus.In_Data;
               LEN_HI: begin
                  count[15:8] <= bus.In_Data;
                  if (over) error <= 1'b1;
               end
               DATA: begin
                  bcnt <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     wr_en   <= 1'b1;
                     wr_data <= DATA_WIDTH'({shift, bus.In_Data});
                     wr_addr <= DATA_WIDTH'({idx, 2'b00});
                     idx     <= idx + 16'd1;
                  end else begin
                     shift <= {shift[15:0], bus.In_Data};
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               CHECK: begin
                  if (bus.In_Data != csum) error <= 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign bus.In_Ready   = ready;
   assign bus.Busy       = busy;
   assign bus.Done       = (state == FINISH);
   assign bus.Wr_En      = wr_en;
   assign bus.Wr_Address = wr_addr;
   assign bus.Wr_Data    = wr_data;
   assign bus.Error      = error;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed and randomized loads against a stream-level model of instruction_loader.
// Checksum expectations follow LOADER_CHECKSUM_EN when the bench is built with it.
module tb_instruction_loader;
   localparam int DW    = 32;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   instruction_loader_if #(.DATA_WIDTH(DW)) bus ();

   instruction_loader #(
      .DATA_WIDTH(DW),
      .MEM_DEPTH (DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int          checks   = 0;
   int          failures = 0;
   int          dones    = 0;
   logic [63:0] got[$];

   always @(negedge clk) begin
      if (bus.Wr_En === 1'b1) got.push_back({bus.Wr_Address, bus.Wr_Data});
      if (bus.Done === 1'b1) dones++;
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // gap: 0 = back-to-back, 1 = random idle cycles, 2 = valid every other cycle
   task automatic send(input logic [7:0] b, input int gap);
      int t;
      if (gap == 1 && $urandom_range(0, 1) == 1) begin
         bus.In_Valid = 1'b0;
         bus.In_Data  = 8'($urandom);
         @(posedge clk); #1;
      end
      if (gap == 2) begin
         bus.In_Valid = 1'b0;
         @(posedge clk); #1;
      end
      check("busy_during_load", 64'(bus.Busy), 64'd1);
      bus.In_Valid = 1'b1;
      bus.In_Data  = b;
      t = 0;
      while (bus.In_Ready !== 1'b1 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check("ready_wait_expired", 64'(t >= 20), 64'd0);
      @(posedge clk); #1;
      bus.In_Valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.Start = 1'b1;
      @(posedge clk); #1;
      bus.Start = 1'b0;
   endtask

   task automatic run_load(input string tag, input logic [15:0] n,
                           input logic [31:0] words[$], input bit bad_sum,
                           input int gap);
      logic [7:0]  s[$];
      logic [63:0] exp[$];
      logic [7:0]  x;
      bit          over;
      bit          experr;
      int          m;
      over   = (int'(n) > DEPTH);
      experr = over;
      s.delete();
      exp.delete();
      s.push_back(n[7:0]);
      s.push_back(n[15:8]);
      if (!over) begin
         for (int k = 0; k < int'(n); k++) begin
            s.push_back(words[k][31:24]);
            s.push_back(words[k][23:16]);
            s.push_back(words[k][15:8]);
            s.push_back(words[k][7:0]);
            exp.push_back({32'(k * 4), words[k]});
         end
      end
`ifdef LOADER_CHECKSUM_EN
      if (!over) begin
         x = 8'h00;
         foreach (s[i]) x = x ^ s[i];
         if (bad_sum) begin
            x      = x ^ 8'h01;
            experr = 1'b1;
         end
         s.push_back(x);
      end
`else
      x = 8'h00;
      if (bad_sum) x = 8'h01;
`endif
      got.delete();
      dones = 0;
      pulse_start();
      check({tag, "_busy_after_start"}, 64'(bus.Busy), 64'd1);
      check({tag, "_ready_after_start"}, 64'(bus.In_Ready), 64'd1);
      check({tag, "_error_cleared"}, 64'(bus.Error), 64'd0);
      foreach (s[i]) send(s[i], gap);
      check({tag, "_done_after_last"}, 64'(bus.Done), 64'd1);
      check({tag, "_busy_drop"}, 64'(bus.Busy), 64'd0);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, 64'(bus.Done), 64'd0);
      check({tag, "_done_count"}, 64'(dones), 64'd1);
      check({tag, "_error"}, 64'(bus.Error), 64'(experr));
      check({tag, "_write_count"}, 64'(got.size()), 64'(exp.size()));
      m = (got.size() < exp.size()) ? got.size() : exp.size();
      for (int i = 0; i < m; i++)
         check({tag, "_write"}, got[i], exp[i]);
   endtask

   initial begin
      logic [31:0] w[$];
      int          sz;

      rst          = 1'b1;
      bus.Start    = 1'b0;
      bus.In_Valid = 1'b0;
      bus.In_Data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.In_Ready), 64'd0);
      check("rst_wr_en", 64'(bus.Wr_En), 64'd0);
      check("rst_wr_address", 64'(bus.Wr_Address), 64'd0);
      check("rst_wr_data", 64'(bus.Wr_Data), 64'd0);
      check("rst_busy", 64'(bus.Busy), 64'd0);
      check("rst_done", 64'(bus.Done), 64'd0);
      check("rst_error", 64'(bus.Error), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      w = {32'h00443000};
      run_load("single", 16'd1, w, 1'b0, 0);
`ifdef LOADER_CHECKSUM_EN
      run_load("single_badsum", 16'd1, w, 1'b1, 0);
`endif

      w = {32'h12345678, 32'hDEADBEEF, 32'h0000_0013};
      run_load("three_toggle", 16'd3, w, 1'b0, 2);

      w.delete();
      run_load("zero", 16'd0, w, 1'b0, 0);
      run_load("over257", 16'd257, w, 1'b0, 0);
      run_load("overmax", 16'hFFFF, w, 1'b0, 1);

      w = {32'hCAFEF00D};
      run_load("after_error", 16'd1, w, 1'b0, 0);

      // reset in the middle of word 1
      got.delete();
      pulse_start();
      send(8'h02, 0);
      send(8'h00, 0);
      send(8'hA1, 0);
      send(8'hB2, 0);
      send(8'hC3, 0);
      send(8'hD4, 0);
      send(8'h11, 0);
      send(8'h22, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_in_ready", 64'(bus.In_Ready), 64'd0);
      check("midrst_wr_en", 64'(bus.Wr_En), 64'd0);
      check("midrst_wr_address", 64'(bus.Wr_Address), 64'd0);
      check("midrst_wr_data", 64'(bus.Wr_Data), 64'd0);
      check("midrst_busy", 64'(bus.Busy), 64'd0);
      check("midrst_done", 64'(bus.Done), 64'd0);
      check("midrst_error", 64'(bus.Error), 64'd0);
      sz = got.size();
      check("midrst_first_word", 64'(sz), 64'd1);
      bus.In_Valid = 1'b1;
      bus.In_Data  = 8'h33;
      repeat (6) @(posedge clk);
      #1;
      bus.In_Valid = 1'b0;
      check("midrst_no_more_writes", 64'(got.size()), 64'(sz));

      w = {32'h0BADC0DE, 32'h00000001};
      run_load("after_midrst", 16'd2, w, 1'b0, 0);

      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(1, 9);
         w.delete();
         for (int k = 0; k < n; k++) w.push_back($urandom);
         run_load("random", 16'(n), w, 1'($urandom_range(0, 1)), 1);
      end

      w.delete();
      for (int k = 0; k < DEPTH; k++) w.push_back($urandom);
      run_load("full_depth", 16'(DEPTH), w, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
